// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream in, registered 3x3 neighbourhood out.
// Two line buffers hold the previous two rows. A two-column history per row
// supplies the left and centre columns of each window.
// Optional build macro GRAY_CONVERT_EN: pix_in becomes 24-bit {r,g,b}, and an
// input register stage converts it to grey as (r+g+b)/3. This adds one clock
// of latency.
module window_gen_3x3 #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned COORD_W    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               pix_valid,
`ifdef GRAY_CONVERT_EN
    input  logic [23:0]        pix_in,
`else
    input  logic [7:0]         pix_in,
`endif
    output logic [7:0]         a1,
    output logic [7:0]         a2,
    output logic [7:0]         a3,
    output logic [7:0]         a4,
    output logic [7:0]         a5,
    output logic [7:0]         a6,
    output logic [7:0]         a7,
    output logic [7:0]         a8,
    output logic [7:0]         a9,
    output logic               win_valid,
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
    output logic               frame_done
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned AW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Stream as seen by the window core (optionally after grey conversion)
    logic             s_valid;
    logic             s_start;
    logic [PIX_W-1:0] s_pix;

`ifdef GRAY_CONVERT_EN
    logic             in_valid_q;
    logic             in_start_q;
    logic [PIX_W-1:0] in_pix_q;
    logic [9:0]       rgb_sum;

    assign rgb_sum = 10'(pix_in[23:16]) + 10'(pix_in[15:8]) + 10'(pix_in[7:0]);

    // Input stage: grey conversion, with valid/start delayed alongside the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_start_q <= 1'b0;
            in_pix_q   <= '0;
        end else begin
            in_valid_q <= pix_valid;
            in_start_q <= frame_start;
            in_pix_q   <= PIX_W'(rgb_sum / 10'd3);
        end
    end

    assign s_valid = in_valid_q;
    assign s_start = in_start_q;
    assign s_pix   = in_pix_q;
`else
    assign s_valid = pix_valid;
    assign s_start = frame_start;
    assign s_pix   = pix_in;
`endif

    state_t             state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] cur_row;
    logic [COORD_W-1:0] cur_col;
    logic               accept;
    logic               emit;
    logic               last;

    // State and position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Accept decision, pixel position, next state and window trigger
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cur_row = row_q;
        cur_col = col_q;
        accept  = 1'b0;
        emit    = 1'b0;
        last    = 1'b0;

        if (s_valid && (s_start || state_q == FILL || state_q == STREAM)) begin
            accept = 1'b1;
        end
        // A start pixel is always (0,0), which also aborts any frame in flight
        if (s_start) begin
            cur_row = '0;
            cur_col = '0;
        end

        if (accept) begin
            if (cur_col == COORD_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == COORD_W'(IMG_HEIGHT - 1)) ? cur_row
                                                               : cur_row + COORD_W'(1);
            end else begin
                col_d = cur_col + COORD_W'(1);
                row_d = cur_row;
            end

            emit = (cur_row >= COORD_W'(2)) && (cur_col >= COORD_W'(2));
            last = (cur_row == COORD_W'(IMG_HEIGHT - 1)) &&
                   (cur_col == COORD_W'(IMG_WIDTH - 1));

            if (s_start) begin
                state_d = FILL;
            end else if (state_q == FILL && cur_row >= COORD_W'(2)) begin
                state_d = STREAM;
            end else if (state_q == STREAM && last) begin
                state_d = DONE;
            end
        end
    end

    // Line buffers: lb_mid holds row-1, lb_top holds row-2, both indexed by column
    logic [PIX_W-1:0] lb_mid [IMG_WIDTH];
    logic [PIX_W-1:0] lb_top [IMG_WIDTH];
    logic [AW-1:0]    lb_addr;
    logic [PIX_W-1:0] rd_mid;
    logic [PIX_W-1:0] rd_top;

    assign lb_addr = AW'(cur_col);
    assign rd_mid  = lb_mid[lb_addr];
    assign rd_top  = lb_top[lb_addr];

    // Write the new pixel and push the old row-1 pixel down to row-2
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[lb_addr] <= rd_mid;
            lb_mid[lb_addr] <= s_pix;
        end
    end

    // Column history per window row: [0] = two columns back, [1] = previous column
    logic [PIX_W-1:0] hist_q [3][2];

    // Shift the column history left on every accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                hist_q[r][0] <= '0;
                hist_q[r][1] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                hist_q[r][0] <= hist_q[r][1];
            end
            hist_q[0][1] <= rd_top;
            hist_q[1][1] <= rd_mid;
            hist_q[2][1] <= s_pix;
        end
    end

    logic [PIX_W-1:0]   tap_q [9];
    logic               win_valid_q;
    logic               frame_done_q;
    logic [COORD_W-1:0] win_x_q;
    logic [COORD_W-1:0] win_y_q;

    // Window output register: loads only on emission, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                tap_q[i] <= '0;
            end
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
        end else begin
            win_valid_q  <= emit;
            frame_done_q <= emit && last;
            if (emit) begin
                tap_q[0] <= hist_q[0][0];
                tap_q[1] <= hist_q[0][1];
                tap_q[2] <= rd_top;
                tap_q[3] <= hist_q[1][0];
                tap_q[4] <= hist_q[1][1];
                tap_q[5] <= rd_mid;
                tap_q[6] <= hist_q[2][0];
                tap_q[7] <= hist_q[2][1];
                tap_q[8] <= s_pix;
                win_x_q  <= cur_col - COORD_W'(1);
                win_y_q  <= cur_row - COORD_W'(1);
            end
        end
    end

    assign a1         = tap_q[0];
    assign a2         = tap_q[1];
    assign a3         = tap_q[2];
    assign a4         = tap_q[3];
    assign a5         = tap_q[4];
    assign a6         = tap_q[5];
    assign a7         = tap_q[6];
    assign a8         = tap_q[7];
    assign a9         = tap_q[8];
    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image. The reference model keeps the
// frame as a 2-D array and cuts windows from it by pixel index.
`timescale 1ns/1ps
module tb_window_gen_3x3;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned CW = 12;
`ifdef GRAY_CONVERT_EN
    localparam int unsigned IN_W = 24;
    localparam int          LAT  = 2;
`else
    localparam int unsigned IN_W = 8;
    localparam int          LAT  = 1;
`endif

    typedef struct packed {
        logic [71:0]   taps;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          done;
        logic [31:0]   cyc;
    } win_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic            pix_valid;
    logic [IN_W-1:0] pix_in;
    logic [7:0]      a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic            win_valid;
    logic [CW-1:0]   win_x;
    logic [CW-1:0]   win_y;
    logic            frame_done;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_in(pix_in),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_active = 1'b0;
    int   m_idx    = 0;
    logic [7:0] m_img [H][W];
    win_t exp_q[$];
    win_t obs_q[$];

    function automatic logic [IN_W-1:0] mkpix(input logic [7:0] v);
`ifdef GRAY_CONVERT_EN
        return {v, v, v};
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] to_gray(input logic [IN_W-1:0] p);
`ifdef GRAY_CONVERT_EN
        int s;
        s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
        return 8'(s / 3);
`else
        return p;
`endif
    endfunction

    // Reference: place the pixel by frame index, cut the 3x3 block when complete
    task automatic model(input bit v, input bit s, input logic [IN_W-1:0] p);
        int r;
        int c;
        win_t e;
        if (!v) return;
        if (s) begin
            m_active = 1'b1;
            m_idx    = 0;
        end
        if (!m_active) return;
        r = m_idx / int'(W);
        c = m_idx % int'(W);
        m_img[r][c] = to_gray(p);
        if (r >= 2 && c >= 2) begin
            e.taps = {m_img[r-2][c-2], m_img[r-2][c-1], m_img[r-2][c],
                      m_img[r-1][c-2], m_img[r-1][c-1], m_img[r-1][c],
                      m_img[r][c-2],   m_img[r][c-1],   m_img[r][c]};
            e.x    = CW'(c - 1);
            e.y    = CW'(r - 1);
            e.done = (r == int'(H) - 1) && (c == int'(W) - 1);
            e.cyc  = 32'(cyc + LAT);
            exp_q.push_back(e);
        end
        m_idx++;
        if (m_idx == int'(W * H)) m_active = 1'b0;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // One clock: drive inputs, advance, record any window seen #1 after the edge
    task automatic step(input bit v, input bit s, input logic [IN_W-1:0] p);
        win_t o;
        pix_valid   = v;
        frame_start = s;
        pix_in      = p;
        model(v, s, p);
        @(posedge clk);
        #1;
        cyc++;
        if (win_valid || frame_done) begin
            o.taps = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
            o.x    = win_x;
            o.y    = win_y;
            o.done = frame_done;
            o.cyc  = 32'(cyc);
            obs_q.push_back(o);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int i = 0; i < int'(W * H); i++) begin
            idle(int'($urandom_range(0, max_gap)));
            step(1'b1, i == 0, mkpix(8'(base + i)));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        #13;
        n_checks++;
        if ({a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid, win_x, win_y, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid, win_x, win_y, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int   t10;
        win_t f;
        win_t l;
        model_reset();
        idle(2);
        t10 = 0;
        for (int i = 0; i < int'(W * H); i++) begin
            if (i == 10) t10 = cyc;
            step(1'b1, i == 0, mkpix(8'(i)));
        end
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d windows required 4", obs_q.size());
        end
        f = (obs_q.size() > 0) ? obs_q[0] : '0;
        l = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : '0;
        n_checks++;
        if (f.taps !== {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10} ||
            f.x !== CW'(1) || f.y !== CW'(1) || f.cyc !== 32'(t10 + LAT)) begin
            n_fail++;
            $display("FAIL basic_first: got taps %h x %0d y %0d cyc %0d required 000102040506080 90a x 1 y 1 cyc %0d",
                     f.taps, f.x, f.y, f.cyc, t10 + LAT);
        end
        n_checks++;
        if (l.taps !== {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15} || l.done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_last: got taps %h done %b required 05060709 0a0b0d0e0f done 1", l.taps, l.done);
        end
        n_checks++;
        if ({a1, a2, a3, a4, a5, a6, a7, a8, a9} !== {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15}) begin
            n_fail++;
            $display("FAIL basic_hold: got %h required last window taps", {a1, a2, a3, a4, a5, a6, a7, a8, a9});
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_model_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        model_reset();
        for (int i = 0; i < int'(W * H); i++) begin
            idle(int'($urandom_range(0, 3)));
            step(1'b1, i == 0, mkpix(8'(i)));
            if (i % 2 == 0) idle(1);
        end
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 4) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        n_checks++;
        if (obs_q.size() > 0 && obs_q[0].taps !== {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}) begin
            n_fail++;
            $display("FAIL gaps_first: got %h required 00010204050608090a", obs_q[0].taps);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gaps_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        model_reset();
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, mkpix(8'(i)));
        send_frame(100, 0);
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== 4 || exp_q.size() !== 4) begin
            n_fail++;
            $display("FAIL abort_count: got %0d required 4", obs_q.size());
        end
        n_checks++;
        if (obs_q.size() > 0 &&
            obs_q[0].taps !== {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110}) begin
            n_fail++;
            $display("FAIL abort_first: got %h required 646566686 96a6c6d6e", obs_q[0].taps);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        model_reset();
        for (int i = 0; i < 11; i++) step(1'b1, i == 0, mkpix(8'(i + 1)));
        idle(LAT);
        step(1'b1, 1'b0, mkpix(8'd77));
        #2;
        pix_valid = 1'b0;
        rst       = 1'b1;
        #1;
        n_checks++;
        if ({a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid, win_x, win_y, frame_done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h required 0",
                     {a1, a2, a3, a4, a5, a6, a7, a8, a9, win_valid, win_x, win_y, frame_done});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mkpix(8'(200 + i)));
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL async_reset_nostart: got %0d windows required 0", obs_q.size());
        end
        send_frame(50, 1);
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 4) begin
            n_fail++;
            $display("FAIL async_reset_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL async_reset_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_done_extra();
        model_reset();
        send_frame(20, 0);
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mkpix(8'(250 + i)));
        idle(2);
        send_frame(40, 2);
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== exp_q.size() || obs_q.size() !== 8) begin
            n_fail++;
            $display("FAIL done_extra_count: got %0d required 8", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL done_extra_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        model_reset();
        for (int f = 0; f < 4; f++) begin
            n = (f == 1) ? int'($urandom_range(5, 14)) : int'(W * H);
            for (int i = 0; i < n; i++) begin
                for (int g = int'($urandom_range(0, 2)); g > 0; g--)
                    step(1'b0, 1'($urandom_range(0, 1)), IN_W'($urandom));
                step(1'b1, i == 0, IN_W'($urandom));
            end
        end
        idle(LAT + 2);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_win%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef GRAY_CONVERT_EN
    task automatic test_gray();
        int t10;
        model_reset();
        t10 = 0;
        for (int i = 0; i < int'(W * H); i++) begin
            if (i == 10) t10 = cyc;
            step(1'b1, i == 0, {8'd30, 8'd60, 8'd90});
        end
        idle(4);
        n_checks++;
        if (obs_q.size() !== 4) begin
            n_fail++;
            $display("FAIL gray_count: got %0d required 4", obs_q.size());
        end
        n_checks++;
        if (obs_q.size() > 0 && obs_q[0].cyc !== 32'(t10 + 2)) begin
            n_fail++;
            $display("FAIL gray_latency: got cycle %0d required %0d", obs_q[0].cyc, t10 + 2);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].taps !== {9{8'd60}}) begin
                n_fail++;
                $display("FAIL gray_taps%0d: got %h required all 3c", i, obs_q[i].taps);
            end
        end
        model_reset();
        for (int i = 0; i < int'(W * H); i++) step(1'b1, i == 0, 24'hffffff);
        idle(4);
        n_checks++;
        if (obs_q.size() !== 4 || obs_q[0].taps !== {9{8'hff}}) begin
            n_fail++;
            $display("FAIL gray_white: got %0d windows first %h required 4 windows all ff",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].taps : 72'h0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_async_reset();
        test_done_extra();
        test_random();
`ifdef GRAY_CONVERT_EN
        test_gray();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Producer side of the 3x3 neighbourhood interface used by the filter stage (edge detect / denoise / sharpen).
- Accepts a raster-order pixel stream and buffers two full lines internally.
- Presents a registered 3x3 window on a1..a9 with a valid strobe and centre coordinates, ready to drive the filter's a1..a9 inputs directly.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- COORD_W, 12, width of column/row counters and coordinate outputs (2^COORD_W > max(IMG_WIDTH, IMG_HEIGHT))

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  qualified by pix_valid; marks the first pixel (0,0) of a frame
- pix_valid  in  1  pix_in valid this cycle; gaps allowed, no backpressure
- pix_in  in  8  grey pixel (24 bits {r,g,b} when GRAY_CONVERT_EN)
- a1..a9  out  8 each  window: a1 a2 a3 = top row, a4 a5 a6 = middle, a7 a8 a9 = bottom; left to right
- win_valid  out  1  a1..a9, win_x, win_y valid this cycle (one-cycle strobe per window)
- win_x  out  COORD_W  column of window centre (a5)
- win_y  out  COORD_W  row of window centre (a5)
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, counters 0, state IDLE. Line-buffer RAM contents are don't-care.
- Accept: a pixel is accepted when pix_valid=1 and state is not IDLE/DONE. The exception is frame_start=1, which is accepted from any state.
- Storage: two line buffers of IMG_WIDTH x 8, forming a circular line pair indexed by col.
  - On accept at (row, col): read the stored pixels at col (rows row-1 and row-2), write pix_in.
  - Shift a 3x3 register array left by one column.
- FSM:
  - IDLE -> FILL on frame_start & pix_valid.
  - FILL (row < 2) -> STREAM when the first pixel of row 2 is accepted.
  - STREAM -> DONE after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DONE: pix_valid without frame_start is ignored. frame_start & pix_valid -> FILL, and that pixel is (0,0) of the new frame.
  - frame_start in FILL/STREAM aborts the current frame: counters are forced to (0,0), the pixel is taken as (0,0), state -> FILL, and no window of the aborted frame is emitted afterwards.
- Counters: col increments per accept and wraps at IMG_WIDTH-1 -> 0 with row+1. row stops at IMG_HEIGHT-1.
- Window emission:
  - Trigger: accept of pixel (r,c) with r>=2 and c>=2.
  - Cycle after the accept: win_valid=1, window = pixels rows r-2..r x cols c-2..c, win_x=c-1, win_y=r-1.
  - Latency: 1 clk from accept to window.
  - Borders: no window for border centres. Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - Wrap: the column shift register is not cleared at line wrap. Windows are suppressed for c<2 instead.
- Holding: a1..a9, win_x, win_y keep their last values when win_valid=0.
- frame_done: asserted with the window centred at (IMG_HEIGHT-2, IMG_WIDTH-2).
- Arithmetic: pixels are passed unmodified. No scaling.
- Reset mid-frame: immediate return to reset values. The next frame requires frame_start.

Optional Feature:
- Macro GRAY_CONVERT_EN.
- Defined:
  - pix_in is 24 bits {r[23:16], g[15:8], b[7:0]}.
  - An input register stage computes grey = (r+g+b)/3 with a 10-bit sum and integer floor division.
  - pix_valid and frame_start are delayed with the data.
  - Accept-to-window latency becomes 2 clk.
- Undefined: pix_in is 8-bit grey, latency 1 clk.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), pixels 0..15 raster, continuous valid:
  - Exactly 4 windows.
  - First: a1..a9 = 0,1,2,4,5,6,8,9,10, win_x=1, win_y=1, one clk after pixel 10 accepted.
  - Last: 5,6,7,9,10,11,13,14,15 with frame_done=1.
- Same frame with pix_valid toggling 1/0 and random 0-3 cycle gaps -> identical window sequence and values; win_valid never asserted during gaps.
- frame_start re-asserted at pixel 6 of frame 1, then full frame 2 (values 100..115) -> no windows after the abort from frame 1; frame 2's first window is 100,101,102,104,105,106,108,109,110.
- rst pulsed asynchronously mid-STREAM -> outputs 0 immediately. 5 pix_valid pixels without frame_start -> no win_valid. A following full frame is correct.
- After DONE, 3 extra pix_valid pixels without frame_start -> ignored; next frame_start frame correct.
- GRAY_CONVERT_EN build, every pixel {30,60,90} -> all window taps 60, latency 2 clk. Pixel {255,255,255} -> 255.
